// File: rtl/multdiv_seq.sv
// Multicycle signed multiply/divide sequencer: Booth radix-2 multiply and
// restoring divide on magnitudes, one addition per cycle on a shared adder.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, MUL_IT, DIV_ABSA, DIV_ABSB, DIV_IT, DIV_SGN, DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] a_reg, b_reg, hi, lo;
  logic [WIDTH-1:0] r_sh, mul_hi, mul_lo;
  logic [CW-1:0]    cnt;
  logic             qm1, neg, ovf;
  logic             start, last, b_zero;

  assign start  = ctrl_MULT | ctrl_DIV;
  assign last   = cnt == CW'(WIDTH - 1);
  assign b_zero = data_operandB == '0;

  // hi doubles as partial remainder, lo as quotient during divide
  assign r_sh   = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign mul_hi = {add_sum[WIDTH-1], add_sum[WIDTH-1:1]};
  assign mul_lo = {add_sum[0], lo[WIDTH-1:1]};

  assign data_resultRDY = state == DONE;
  assign busy           = state != IDLE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = IDLE;
      MUL_IT:   if (last) nxt = DONE;
      DIV_ABSA: nxt = DIV_ABSB;
      DIV_ABSB: nxt = DIV_IT;
      DIV_IT:   if (last) nxt = DIV_SGN;
      DIV_SGN:  nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (ctrl_MULT)     nxt = MUL_IT;
    else if (ctrl_DIV) nxt = b_zero ? DONE : DIV_ABSA;
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      MUL_IT: begin
        add_a = hi;
        unique case (1'b1)
          (!lo[0] && qm1): add_b = a_reg;
          (lo[0] && !qm1): begin
            add_b   = ~a_reg;
            add_cin = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
      DIV_ABSA: begin
        add_a   = a_reg[WIDTH-1] ? ~a_reg : a_reg;
        add_cin = a_reg[WIDTH-1];
      end
      DIV_ABSB: begin
        add_a   = b_reg[WIDTH-1] ? ~b_reg : b_reg;
        add_cin = b_reg[WIDTH-1];
      end
      DIV_IT: begin
        add_a   = r_sh;
        add_b   = ~b_reg;
        add_cin = 1'b1;
      end
      DIV_SGN: begin
        add_a   = neg ? ~lo : lo;
        add_cin = neg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg          <= '0;
      b_reg          <= '0;
      hi             <= '0;
      lo             <= '0;
      qm1            <= 1'b0;
      cnt            <= '0;
      neg            <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      a_reg          <= data_operandA;
      b_reg          <= data_operandB;
      hi             <= '0;
      lo             <= data_operandB;
      qm1            <= 1'b0;
      cnt            <= '0;
      neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      ovf            <= (data_operandA == MIN) && (data_operandB == '1);
      data_result    <= '0;
      data_exception <= !ctrl_MULT && b_zero;
    end else begin
      case (state)
        MUL_IT: begin
          hi  <= mul_hi;
          lo  <= mul_lo;
          qm1 <= lo[0];
          if (!last) cnt <= cnt + 1'b1;
          if (last) begin
            data_result    <= mul_lo;
            data_exception <= mul_hi != {WIDTH{mul_lo[WIDTH-1]}};
          end
        end
        DIV_ABSA: lo <= add_sum;
        DIV_ABSB: b_reg <= add_sum;
        DIV_IT: begin
          hi <= add_cout ? add_sum : r_sh;
          lo <= {lo[WIDTH-2:0], add_cout};
          if (!last) cnt <= cnt + 1'b1;
        end
        DIV_SGN: begin
          data_result    <= add_sum;
          data_exception <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq with a behavioural shared adder.
// Table of vectors plus abort, priority and mid-op reset sequences.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] add_sum, add_a, add_b;
  logic        add_cout, add_cin;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  multdiv_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .add_sum(add_sum), .add_cout(add_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  typedef struct {
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
    int          cyc;
  } vec_t;

  vec_t v[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive start so it is sampled on the next edge (edge 0); returns in cycle 1.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(output int cyc, output bit busy_bad);
    cyc = 1;
    busy_bad = 1'b0;
    while (!data_resultRDY && cyc < 60) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clock);
      #1;
      cyc++;
    end
    if (!busy) busy_bad = 1'b1;
  endtask

  initial begin
    int cyc;
    bit bb;
    bit seen;
    logic [31:0] held;

    v[0]  = '{0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 33};
    v[1]  = '{0, 32'h00010000, 32'h00010000, 32'h00000000, 1, 33};
    v[2]  = '{0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 0, 33};
    v[3]  = '{0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30,       0, 33};
    v[4]  = '{0, 32'h00012345, 32'h00000100, 32'h01234500, 0, 33};
    v[5]  = '{0, 32'd1,        32'h80000000, 32'h80000000, 0, 33};
    v[6]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 33};
    v[7]  = '{1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 0, 36};
    v[8]  = '{1, 32'd9,        32'd0,        32'd0,        1, 1};
    v[9]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 36};
    v[10] = '{1, 32'd100,      32'd7,        32'd14,       0, 36};
    v[11] = '{1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0, 36};
    v[12] = '{1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       0, 36};
    v[13] = '{1, 32'd3,        32'd10,       32'd0,        0, 36};
    v[14] = '{1, 32'h7FFFFFFF, 32'h80000000, 32'd0,        0, 36};

    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", data_result, 32'd0);
    chk("rst_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    chk("rst_add", add_a | add_b | {31'd0, add_cin}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 15; i++) begin
      start_op(!v[i].div, v[i].div, v[i].a, v[i].b);
      wait_rdy(cyc, bb);
      chk($sformatf("v%0d_cyc", i), cyc, v[i].cyc);
      chk($sformatf("v%0d_res", i), data_result, v[i].res);
      chk($sformatf("v%0d_exc", i), {31'd0, data_exception}, {31'd0, v[i].exc});
      chk($sformatf("v%0d_busy", i), {31'd0, bb}, 32'd0);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_after", i), {30'd0, data_resultRDY, busy}, 32'd0);
      chk($sformatf("v%0d_hold", i), data_result, v[i].res);
      chk($sformatf("v%0d_add0", i), add_a | add_b | {31'd0, add_cin}, 32'd0);
    end

    // DIV restart during cycle 10 of a MULT
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    seen = 1'b0;
    repeat (9) begin
      if (data_resultRDY) seen = 1'b1;
      @(posedge clock);
      #1;
    end
    start_op(1'b0, 1'b1, 32'hFFFFFFEF, 32'd5);
    chk("abort_clear", data_result, 32'd0);
    wait_rdy(cyc, bb);
    chk("abort_no_rdy", {31'd0, seen}, 32'd0);
    chk("abort_cyc", cyc, 36);
    chk("abort_res", data_result, 32'hFFFFFFFD);
    @(posedge clock);
    #1;

    // Both starts together: multiply wins
    start_op(1'b1, 1'b1, 32'd7, 32'hFFFFFFFD);
    wait_rdy(cyc, bb);
    chk("both_cyc", cyc, 33);
    chk("both_res", data_result, 32'hFFFFFFEB);
    @(posedge clock);
    #1;

    // Reset in cycle 20 of a DIV
    start_op(1'b0, 1'b1, 32'hFFFFFFEF, 32'd5);
    repeat (19) @(posedge clock);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    chk("mid_rst_add", add_a | add_b | {31'd0, add_cin}, 32'd0);
    chk("mid_rst_res", data_result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    held = 32'd0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) held = held + 1;
    end
    chk("mid_rst_no_rdy", held, 32'd0);
    start_op(1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA);
    wait_rdy(cyc, bb);
    chk("post_rst_cyc", cyc, 33);
    chk("post_rst_res", data_result, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
